// File: rtl/alarm_pkg.sv
// alarm_pkg
//   Shared definitions for the alarm clock datapath: time-stamp width and
//   range, default alarm timing constants and the alarm FSM state encoding.
package alarm_pkg;

    localparam int unsigned STAMP_W                 = 24;
    localparam int unsigned MAX_COUNT               = 8640000;  // hundredths per day
    localparam int unsigned DEF_SNOOZE_TICKS        = 54000;    // 9 min
    localparam int unsigned DEF_RING_TIMEOUT_TICKS  = 6000;     // 60 s
    localparam int unsigned DEF_BEEP_HALF_TICKS     = 50;       // 0.5 s

    typedef logic [STAMP_W-1:0] stamp_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RINGING,
        SNOOZE
    } alarm_state_e;

endpackage

// File: rtl/stamp_mod_add.sv
// stamp_mod_add
//   Combinational modulo-MAX_COUNT adder for time stamps. Both operands are
//   expected in 0..MAX_COUNT-1, so one conditional subtraction suffices.
//   Ports:
//     a_i, b_i : stamp operands
//     sum_o    : (a_i + b_i) mod MAX_COUNT
module stamp_mod_add
    import alarm_pkg::*;
#(
    parameter int unsigned MAX_COUNT = alarm_pkg::MAX_COUNT
) (
    input  logic [STAMP_W-1:0] a_i,
    input  logic [STAMP_W-1:0] b_i,
    output logic [STAMP_W-1:0] sum_o
);

    localparam logic [STAMP_W:0] MAX_EXT = (STAMP_W+1)'(MAX_COUNT);

    logic [STAMP_W:0] raw_sum;
    logic [STAMP_W:0] wrapped;

    always_comb begin
        raw_sum = {1'b0, a_i} + {1'b0, b_i};
        wrapped = raw_sum - MAX_EXT;
        if (raw_sum >= MAX_EXT) begin
            sum_o = wrapped[STAMP_W-1:0];
        end else begin
            sum_o = raw_sum[STAMP_W-1:0];
        end
    end

endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger
//   Compares the running clock stamp with the programmed alarm stamp and
//   drives the ring / buzzer / snooze indications, including snooze, stop
//   and ring timeout. Outputs are registered (one cycle after the event).
//   Ports:
//     i_Clk_5MHz          : system clock
//     i_Reset             : synchronous active-high reset
//     i_Clock_Time_Stamp  : current time of day in hundredths
//     i_Alarm_Time_Stamp  : programmed alarm time
//     i_Alarm_Enable      : alarm armed while high
//     i_Snooze, i_Stop    : single-cycle user pulses
//     o_Alarm_Active      : high while ringing
//     o_Buzzer            : beep pattern while ringing
//     o_Snoozing          : high while snoozing
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int unsigned MAX_COUNT          = alarm_pkg::MAX_COUNT,
    parameter int unsigned SNOOZE_TICKS       = DEF_SNOOZE_TICKS,
    parameter int unsigned RING_TIMEOUT_TICKS = DEF_RING_TIMEOUT_TICKS,
    parameter int unsigned BEEP_HALF_TICKS    = DEF_BEEP_HALF_TICKS
) (
    input  logic               i_Clk_5MHz,
    input  logic               i_Reset,
    input  logic [STAMP_W-1:0] i_Clock_Time_Stamp,
    input  logic [STAMP_W-1:0] i_Alarm_Time_Stamp,
    input  logic               i_Alarm_Enable,
    input  logic               i_Snooze,
    input  logic               i_Stop,
    output logic               o_Alarm_Active,
    output logic               o_Buzzer,
    output logic               o_Snoozing
);

    localparam int unsigned RING_W = $clog2(RING_TIMEOUT_TICKS + 1);
    localparam int unsigned BEEP_W = $clog2(BEEP_HALF_TICKS + 1);
    localparam stamp_t      SNOOZE_STAMP = STAMP_W'(SNOOZE_TICKS);

    alarm_state_e       state_q;
    stamp_t             prev_stamp_q;
    logic               prev_valid_q;
    stamp_t             snooze_target_q;
    stamp_t             snooze_target_d;
    logic [RING_W-1:0]  ring_cnt_q;
    logic [BEEP_W-1:0]  beep_cnt_q;
    logic               alarm_active_q;
    logic               buzzer_q;
    logic               snoozing_q;

    logic tick;
    logic alarm_match;
    logic snooze_match;
    logic ring_timeout;
    logic beep_flip;

    stamp_mod_add #(
        .MAX_COUNT (MAX_COUNT)
    ) u_snooze_add (
        .a_i   (i_Clock_Time_Stamp),
        .b_i   (SNOOZE_STAMP),
        .sum_o (snooze_target_d)
    );

    // Any stamp change is a tick; prev_valid_q suppresses the spurious
    // change seen on the first cycle after reset.
    assign tick         = prev_valid_q && (i_Clock_Time_Stamp != prev_stamp_q);
    assign alarm_match  = tick && (i_Clock_Time_Stamp == i_Alarm_Time_Stamp);
    assign snooze_match = tick && (i_Clock_Time_Stamp == snooze_target_q);
    assign ring_timeout = (ring_cnt_q + RING_W'(1)) == RING_W'(RING_TIMEOUT_TICKS);
    assign beep_flip    = (beep_cnt_q + BEEP_W'(1)) == BEEP_W'(BEEP_HALF_TICKS);

    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            state_q         <= IDLE;
            prev_stamp_q    <= '0;
            prev_valid_q    <= 1'b0;
            snooze_target_q <= '0;
            ring_cnt_q      <= '0;
            beep_cnt_q      <= '0;
            alarm_active_q  <= 1'b0;
            buzzer_q        <= 1'b0;
            snoozing_q      <= 1'b0;
        end else begin
            prev_stamp_q <= i_Clock_Time_Stamp;
            prev_valid_q <= 1'b1;

            if (!i_Alarm_Enable) begin
                state_q        <= IDLE;
                alarm_active_q <= 1'b0;
                buzzer_q       <= 1'b0;
                snoozing_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= ARMED;
                    end

                    ARMED: begin
                        if (alarm_match) begin
                            state_q        <= RINGING;
                            ring_cnt_q     <= '0;
                            beep_cnt_q     <= '0;
                            alarm_active_q <= 1'b1;
                            buzzer_q       <= 1'b1;
                        end
                    end

                    RINGING: begin
                        if (i_Stop) begin
                            state_q        <= ARMED;
                            alarm_active_q <= 1'b0;
                            buzzer_q       <= 1'b0;
                        end else if (i_Snooze) begin
                            state_q         <= SNOOZE;
                            snooze_target_q <= snooze_target_d;
                            alarm_active_q  <= 1'b0;
                            buzzer_q        <= 1'b0;
                            snoozing_q      <= 1'b1;
                        end else if (tick) begin
                            if (ring_timeout) begin
                                state_q        <= ARMED;
                                alarm_active_q <= 1'b0;
                                buzzer_q       <= 1'b0;
                            end else begin
                                ring_cnt_q <= ring_cnt_q + RING_W'(1);
                                if (beep_flip) begin
                                    beep_cnt_q <= '0;
                                    buzzer_q   <= ~buzzer_q;
                                end else begin
                                    beep_cnt_q <= beep_cnt_q + BEEP_W'(1);
                                end
                            end
                        end
                    end

                    SNOOZE: begin
                        if (i_Stop) begin
                            state_q    <= ARMED;
                            snoozing_q <= 1'b0;
                        end else if (snooze_match) begin
                            state_q        <= RINGING;
                            ring_cnt_q     <= '0;
                            beep_cnt_q     <= '0;
                            alarm_active_q <= 1'b1;
                            buzzer_q       <= 1'b1;
                            snoozing_q     <= 1'b0;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_Alarm_Active = alarm_active_q;
    assign o_Buzzer       = buzzer_q;
    assign o_Snoozing     = snoozing_q;

endmodule

// File: tb/tb_alarm_trigger.sv
`timescale 1ns/1ps
module tb_alarm_trigger;

    localparam int unsigned MAXC = 8640000;

    logic        clk;
    logic        rst;
    logic [23:0] clock_stamp;
    logic [23:0] alarm_stamp;
    logic        en;
    logic        snz;
    logic        stp;
    logic        o_act;
    logic        o_buz;
    logic        o_snz;

    typedef struct {
        string      tag;
        logic [2:0] exp;   // {active, buzzer, snoozing}
    } sb_item_t;

    sb_item_t sb_q[$];
    int unsigned n_vec;
    int unsigned n_bad;
    int unsigned cur;

    alarm_trigger #(
        .MAX_COUNT          (8640000),
        .SNOOZE_TICKS       (54000),
        .RING_TIMEOUT_TICKS (6000),
        .BEEP_HALF_TICKS    (50)
    ) dut (
        .i_Clk_5MHz         (clk),
        .i_Reset            (rst),
        .i_Clock_Time_Stamp (clock_stamp),
        .i_Alarm_Time_Stamp (alarm_stamp),
        .i_Alarm_Enable     (en),
        .i_Snooze           (snz),
        .i_Stop             (stp),
        .o_Alarm_Active     (o_act),
        .o_Buzzer           (o_buz),
        .o_Snoozing         (o_snz)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs before the edge, optionally queue the
    // expected outputs, then compare whatever is queued just after the edge.
    task automatic cyc(input int unsigned s, input logic sz, input logic sp,
                       input bit chk, input string tag, input logic [2:0] e);
        sb_item_t it;
        @(negedge clk);
        clock_stamp = 24'(s);
        snz = sz;
        stp = sp;
        if (chk) begin
            it.tag = tag;
            it.exp = e;
            sb_q.push_back(it);
        end
        @(posedge clk);
        #1;
        snz = 1'b0;
        stp = 1'b0;
        if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_val(it.tag, {29'd0, o_act, o_buz, o_snz}, {29'd0, it.exp});
        end
    endtask

    // Advance the clock stamp n hundredths, checking only the final cycle.
    task automatic step_n(input int unsigned n, input string tag, input logic [2:0] e);
        for (int unsigned i = 0; i < n; i++) begin
            cur = (cur + 1) % MAXC;
            cyc(cur, 1'b0, 1'b0, (i == n - 1), tag, e);
        end
    endtask

    task automatic jump(input int unsigned s, input string tag, input logic [2:0] e);
        cur = s;
        cyc(cur, 1'b0, 1'b0, 1'b1, tag, e);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        en = 1'b1;
        snz = 1'b0;
        stp = 1'b0;
        alarm_stamp = 24'd2520000;
        cur = 2519990;
        clock_stamp = 24'(cur);

        // Reset state
        cyc(cur, 0, 0, 1, "reset0", 3'b000);
        cyc(cur, 0, 0, 1, "reset1", 3'b000);
        rst = 1'b0;
        cyc(cur, 0, 0, 1, "idle_to_armed", 3'b000);

        // Basic ring and beep pattern
        step_n(9, "pre_alarm", 3'b000);
        step_n(1, "ring_start", 3'b110);
        step_n(49, "beep_hold", 3'b110);
        step_n(1, "beep_toggle", 3'b100);
        step_n(50, "beep_toggle2", 3'b110);

        // Snooze, then ring again at target
        cyc(cur, 1, 0, 1, "snooze_enter", 3'b001);
        jump(2574098, "snooze_wait", 3'b001);
        step_n(1, "snooze_wait2", 3'b001);
        step_n(1, "snooze_ring", 3'b110);

        // Ring timeout counted from the re-ring entry
        step_n(5999, "pre_timeout", 3'b100);
        step_n(1, "timeout", 3'b000);
        step_n(3, "armed_after_timeout", 3'b000);

        // Stop and snooze together, then a long hold on the alarm stamp
        jump(2519999, "pre_ring2", 3'b000);
        step_n(1, "ring2", 3'b110);
        cyc(cur, 1, 1, 1, "stop_snooze", 3'b000);
        for (int unsigned i = 0; i < 50000; i++)
            cyc(cur, 0, 0, (i == 49999), "no_retrigger", 3'b000);
        step_n(1, "after_hold", 3'b000);

        // Jump past the alarm stamp
        jump(2519000, "jump_pre", 3'b000);
        jump(2521000, "jump_past", 3'b000);
        step_n(2, "jump_past_hold", 3'b000);

        // Snooze wrapping through midnight
        alarm_stamp = 24'd8629990;
        jump(8629980, "wrap_pre", 3'b000);
        step_n(10, "wrap_ring", 3'b110);
        step_n(10, "wrap_ringing", 3'b110);
        cyc(cur, 1, 0, 1, "wrap_snooze", 3'b001);
        jump(8639999, "wrap_late", 3'b001);
        step_n(1, "wrap_midnight", 3'b001);
        alarm_stamp = 24'd43999;   // ignored while snoozing
        jump(43999, "alarm_change_snooze", 3'b001);
        step_n(1, "wrap_match", 3'b110);
        cyc(cur, 0, 1, 1, "stop", 3'b000);

        // Alarm change takes effect while armed
        alarm_stamp = 24'd44005;
        step_n(4, "alarm_live_pre", 3'b000);
        step_n(1, "alarm_live", 3'b110);

        // Enable low drops everything
        en = 1'b0;
        cyc(cur, 0, 0, 1, "enable_low", 3'b000);
        en = 1'b1;
        cyc(cur, 0, 0, 1, "enable_high", 3'b000);
        cyc(cur, 1, 0, 1, "snooze_ignored", 3'b000);
        cyc(cur, 0, 1, 1, "stop_ignored", 3'b000);

        // Reset during ringing, then re-arm from IDLE
        alarm_stamp = 24'd50000;
        jump(49999, "pre_ring3", 3'b000);
        step_n(1, "ring3", 3'b110);
        rst = 1'b1;
        cyc(cur, 0, 0, 1, "reset_ring", 3'b000);
        rst = 1'b0;
        cyc(cur, 0, 0, 1, "rearm_idle", 3'b000);
        alarm_stamp = 24'd50002;
        step_n(1, "rearm_pre", 3'b000);
        step_n(1, "rearm_ring", 3'b110);

        check_val("sb_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_trigger.md
# alarm_trigger

- Consumer of the 24-bit hundredths-of-second time stamps produced by the alarm-time and clock-time counters.
- Compares the running clock stamp against the programmed alarm stamp and drives the ring indication and the buzzer pattern.
- Handles snooze, stop and ring timeout.
- Sits between the time counters and the buzzer/LED outputs of the alarm clock.

## Interface
Parameters:
- MAX_COUNT, 8640000, stamps per day; valid stamps are 0..MAX_COUNT-1
- SNOOZE_TICKS, 54000, snooze length in hundredths (9 min)
- RING_TIMEOUT_TICKS, 6000, auto-stop after 60 s of ringing
- BEEP_HALF_TICKS, 50, buzzer on/off half-period in hundredths

Ports:
- i_Clk_5MHz  in  1  system clock; the only clock
- i_Reset  in  1  synchronous, active-high reset
- i_Clock_Time_Stamp  in  24  current time of day, advances +1 per hundredth
- i_Alarm_Time_Stamp  in  24  programmed alarm time
- i_Alarm_Enable  in  1  level; alarm armed when high
- i_Snooze  in  1  debounced single-cycle pulse
- i_Stop  in  1  debounced single-cycle pulse
- o_Alarm_Active  out  1  high while RINGING
- o_Buzzer  out  1  beep pattern while RINGING, else 0
- o_Snoozing  out  1  high while SNOOZE

## Operation
- Tick detection:
  - r_Prev_Stamp registers i_Clock_Time_Stamp every cycle.
  - r_Prev_Valid is cleared by reset and set one cycle later.
  - w_Tick = r_Prev_Valid && (i_Clock_Time_Stamp != r_Prev_Stamp).
  - Any change counts as a tick, including user set jumps.
- Match events:
  - Alarm match: w_Tick && stamp == i_Alarm_Time_Stamp.
  - Snooze match: w_Tick && stamp == r_Snooze_Target.
  - Equality only. A jump past the target does not trigger. Because a match needs a tick, the alarm cannot re-trigger within the same hundredth after Stop.
- States: IDLE, ARMED, RINGING, SNOOZE.
  - IDLE: go to ARMED when i_Alarm_Enable = 1.
  - ARMED: on alarm match, go to RINGING.
  - RINGING:
    - i_Stop → ARMED.
    - Otherwise i_Snooze → SNOOZE; load r_Snooze_Target = (stamp + SNOOZE_TICKS) mod MAX_COUNT.
    - Otherwise ring timeout → ARMED.
  - SNOOZE: i_Stop → ARMED; snooze match → RINGING.
  - Any state: i_Alarm_Enable = 0 → IDLE, with priority over every other transition except reset.
- Modulo add:
  - 25-bit sum; subtract MAX_COUNT when sum >= MAX_COUNT.
  - Result is always 0..MAX_COUNT-1.
- Ring counter:
  - Cleared on entry to RINGING; increments on each w_Tick in RINGING.
  - Reaching RING_TIMEOUT_TICKS means timeout.
- Beep counter:
  - Cleared on entry to RINGING.
  - o_Buzzer = 1 on entry and toggles every BEEP_HALF_TICKS ticks.
- Alarm stamp changes:
  - While in SNOOZE or RINGING: no effect on the current ring or snooze.
  - While ARMED: takes effect immediately.
- i_Snooze outside RINGING is ignored. i_Stop in IDLE/ARMED is ignored.

## Timing
- Reset: state IDLE; all outputs 0; counters 0; r_Snooze_Target 0; r_Prev_Valid 0.
- Registered outputs:
  - The stamp change is visible on input in cycle N.
  - w_Tick and the state update happen at the edge ending cycle N.
  - o_Alarm_Active / o_Buzzer / o_Snoozing are valid in cycle N+1 (1-cycle latency).
- Stop/Snooze pulses: the state changes at the edge ending the pulse cycle; outputs update in the next cycle.
- Priorities:
  - Reset > enable low > Stop > Snooze > timeout/match.
  - Stop and Snooze in the same cycle → ARMED.
- Reset mid-ring: outputs drop to 0 on the cycle after the reset edge. No snooze target is retained.
- Wrap-around: a snooze target that wraps past midnight (e.g. 8630000 + 54000 = 44000) matches normally.
- The first cycle after reset never produces a tick, even if the stamp differs from 0.

## Structure
- Shared package alarm_pkg:
  - MAX_COUNT (8640000) and stamp width (24).
  - State enum {IDLE, ARMED, RINGING, SNOOZE}.
  - Default SNOOZE/RING/BEEP constants.
- One sub-module, stamp_mod_add: combinational modulo-MAX_COUNT adder. It is reused later by the clock time-zone offset.
- The tick detector and FSM stay in alarm_trigger.

## Test plan
- Alarm 2520000 (07:00), enabled, clock stepping 2519999→2520000 → o_Alarm_Active = 1 and o_Buzzer = 1 one cycle after the step; o_Buzzer toggles after 50 ticks.
- Ringing, i_Snooze at stamp 2520100 → o_Snoozing = 1, o_Alarm_Active = 0; rings again one cycle after stamp 2574100.
- Ringing with no input → after 6000 ticks returns to ARMED; outputs 0 at stamp 2526000.
- Snooze at 8630000 → target 44000; rings after the clock wraps through 0 to 44000.
- Ringing, i_Stop and i_Snooze in the same cycle → ARMED, o_Snoozing stays 0. The stamp holding at 2520000 for 50000 cycles does not re-trigger.
- Two cases:
  - Clock jumps 2519000→2521000 → no ring.
  - i_Reset during RINGING → all outputs 0 the next cycle; the FSM re-arms from IDLE.
